// File: rtl/fg_bbox_tracker.sv
// Foreground bounding-box tracker.
// Thresholds the background-subtraction difference stream and drops isolated
// hits with a horizontal run-length filter. It accumulates the bounding box and
// the foreground pixel count of each frame, and publishes them at frame end
// with a one-cycle valid strobe.
module fg_bbox_tracker #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned MIN_RUN  = 2
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       vtcvde,
  input  logic [4:0] data_in,
  input  logic [4:0] threshold,
  output logic [9:0] bbox_x_min,
  output logic [9:0] bbox_x_max,
  output logic [8:0] bbox_y_min,
  output logic [8:0] bbox_y_max,
  output logic [18:0] fg_count,
  output logic       bbox_empty,
  output logic       bbox_valid
);

  localparam logic [9:0]  X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [8:0]  Y_LAST    = 9'(V_ACTIVE - 1);
  localparam logic [3:0]  RUN_MAX   = 4'd15;
  localparam logic [3:0]  MIN_RUN_W = 4'(MIN_RUN);
  localparam logic [18:0] CREDIT    = 19'(MIN_RUN);

  logic [9:0]  x_cnt;
  logic        x_done;
  logic [8:0]  y_cnt;
  logic        vde_d;
  logic [3:0]  run_cnt;
  logic [9:0]  run_start;

  logic [9:0]  w_x_min, w_x_max;
  logic [8:0]  w_y_min, w_y_max;
  logic [18:0] w_count;
  logic        w_empty;

  logic        line_end, frame_end, hit, credit, extend;
  logic [9:0]  run_start_cur;

  // Line/frame boundaries and per-pixel qualification
  always_comb begin
    line_end      = 1'b0;
    frame_end     = 1'b0;
    hit           = 1'b0;
    credit        = 1'b0;
    extend        = 1'b0;
    run_start_cur = run_start;
    line_end  = !vtcvde && vde_d;
    frame_end = line_end && (y_cnt == Y_LAST);
    hit       = vtcvde && (data_in >= threshold);
    if (run_cnt == 4'd0)
      run_start_cur = x_cnt;
    // x_done marks pixels past the saturated last column; they may extend a
    // run but never contribute to the box or the count.
    credit = hit && !x_done && (run_cnt == MIN_RUN_W - 4'd1);
    extend = hit && !x_done && (run_cnt >= MIN_RUN_W);
  end

  // Timing counters, run filter, working accumulators and published results
  always_ff @(posedge pclk) begin
    if (reset) begin
      x_cnt      <= '0;
      x_done     <= 1'b0;
      y_cnt      <= '0;
      vde_d      <= 1'b0;
      run_cnt    <= '0;
      run_start  <= '0;
      w_x_min    <= '1;
      w_x_max    <= '0;
      w_y_min    <= '1;
      w_y_max    <= '0;
      w_count    <= '0;
      w_empty    <= 1'b1;
      bbox_x_min <= '0;
      bbox_x_max <= '0;
      bbox_y_min <= '0;
      bbox_y_max <= '0;
      fg_count   <= '0;
      bbox_empty <= 1'b1;
      bbox_valid <= 1'b0;
    end else begin
      vde_d      <= vtcvde;
      bbox_valid <= 1'b0;

      if (vtcvde) begin
        if (x_cnt == X_LAST)
          x_done <= 1'b1;
        else
          x_cnt <= x_cnt + 10'd1;
        if (hit) begin
          if (run_cnt != RUN_MAX)
            run_cnt <= run_cnt + 4'd1;
          if (run_cnt == 4'd0)
            run_start <= x_cnt;
        end else begin
          run_cnt <= '0;
        end
      end else begin
        run_cnt <= '0;
      end

      if (line_end) begin
        x_cnt  <= '0;
        x_done <= 1'b0;
        y_cnt  <= (y_cnt == Y_LAST) ? '0 : y_cnt + 9'd1;
      end

      if (credit || extend) begin
        if (run_start_cur < w_x_min) w_x_min <= run_start_cur;
        if (x_cnt > w_x_max)         w_x_max <= x_cnt;
        if (y_cnt < w_y_min)         w_y_min <= y_cnt;
        if (y_cnt > w_y_max)         w_y_max <= y_cnt;
        w_count <= w_count + (credit ? CREDIT : 19'd1);
        w_empty <= 1'b0;
      end

      if (frame_end) begin
        bbox_x_min <= w_empty ? '0 : w_x_min;
        bbox_x_max <= w_empty ? '0 : w_x_max;
        bbox_y_min <= w_empty ? '0 : w_y_min;
        bbox_y_max <= w_empty ? '0 : w_y_max;
        fg_count   <= w_count;
        bbox_empty <= w_empty;
        bbox_valid <= 1'b1;
        w_x_min    <= '1;
        w_x_max    <= '0;
        w_y_min    <= '1;
        w_y_max    <= '0;
        w_count    <= '0;
        w_empty    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fg_bbox_tracker.sv
// Directed bench for fg_bbox_tracker on an 8x4 frame.
// Two instances share the stimulus: MIN_RUN=2 (dut) and MIN_RUN=1 (dut1).
module tb_fg_bbox_tracker;

  logic        pclk = 1'b0;
  logic        reset, vtcvde;
  logic [4:0]  data_in, threshold;

  logic [9:0]  x_min0, x_max0, x_min1, x_max1;
  logic [8:0]  y_min0, y_max0, y_min1, y_max1;
  logic [18:0] cnt0, cnt1;
  logic        emp0, emp1, vld0, vld1;

  int unsigned tests = 0;
  int unsigned failed = 0;
  int unsigned pulses = 0;
  int unsigned pulse_mark;

  logic [3:0][7:0][4:0] fr;

  fg_bbox_tracker #(.H_ACTIVE(8), .V_ACTIVE(4), .MIN_RUN(2)) dut (
    .pclk(pclk), .reset(reset), .vtcvde(vtcvde), .data_in(data_in),
    .threshold(threshold), .bbox_x_min(x_min0), .bbox_x_max(x_max0),
    .bbox_y_min(y_min0), .bbox_y_max(y_max0), .fg_count(cnt0),
    .bbox_empty(emp0), .bbox_valid(vld0)
  );

  fg_bbox_tracker #(.H_ACTIVE(8), .V_ACTIVE(4), .MIN_RUN(1)) dut1 (
    .pclk(pclk), .reset(reset), .vtcvde(vtcvde), .data_in(data_in),
    .threshold(threshold), .bbox_x_min(x_min1), .bbox_x_max(x_max1),
    .bbox_y_min(y_min1), .bbox_y_max(y_max1), .fg_count(cnt1),
    .bbox_empty(emp1), .bbox_valid(vld1)
  );

  always #5 pclk = ~pclk;

  // Count valid strobes of the MIN_RUN=2 instance
  always @(posedge pclk) if (vld0 === 1'b1) pulses = pulses + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_box0(input string tag, input int unsigned xa, input int unsigned xb,
                            input int unsigned ya, input int unsigned yb,
                            input int unsigned c, input logic e);
    check({tag, ".valid"}, 32'(vld0), 32'd1);
    check({tag, ".xmin"}, 32'(x_min0), xa);
    check({tag, ".xmax"}, 32'(x_max0), xb);
    check({tag, ".ymin"}, 32'(y_min0), ya);
    check({tag, ".ymax"}, 32'(y_max0), yb);
    check({tag, ".count"}, 32'(cnt0), c);
    check({tag, ".empty"}, 32'(emp0), 32'(e));
  endtask

  task automatic check_box1(input string tag, input int unsigned xa, input int unsigned xb,
                            input int unsigned ya, input int unsigned yb,
                            input int unsigned c, input logic e);
    check({tag, ".valid1"}, 32'(vld1), 32'd1);
    check({tag, ".xmin1"}, 32'(x_min1), xa);
    check({tag, ".xmax1"}, 32'(x_max1), xb);
    check({tag, ".ymin1"}, 32'(y_min1), ya);
    check({tag, ".ymax1"}, 32'(y_max1), yb);
    check({tag, ".count1"}, 32'(cnt1), c);
    check({tag, ".empty1"}, 32'(emp1), 32'(e));
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic gap(input int unsigned n);
    vtcvde  = 1'b0;
    data_in = '0;
    tick(n);
  endtask

  // Pixels beyond column 7 are driven as 31
  task automatic pixels(input logic [7:0][4:0] px, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      vtcvde  = 1'b1;
      data_in = (i < 8) ? px[i] : 5'd31;
      tick(1);
    end
  endtask

  // Full frame; returns just after the frame-end edge. n0 = length of line 0.
  task automatic frame(input logic [3:0][7:0][4:0] f, input int unsigned n0);
    for (int unsigned y = 0; y < 4; y++) begin
      pixels(f[y], (y == 0) ? n0 : 8);
      gap((y == 3) ? 1 : 2);
    end
  endtask

  initial begin
    reset = 1'b1; vtcvde = 1'b0; data_in = '0; threshold = 5'd4;
    tick(3);
    check("rst.valid", 32'(vld0), 32'd0);
    check("rst.empty", 32'(emp0), 32'd1);
    check("rst.count", 32'(cnt0), 32'd0);
    check("rst.xmin", 32'(x_min0), 32'd0);
    reset = 1'b0;
    tick(2);

    // All-zero frame, threshold 4
    fr = '0;
    frame(fr, 8);
    check_box0("zero", 0, 0, 0, 0, 0, 1'b1);
    tick(1);
    check("zero.valid_low", 32'(vld0), 32'd0);

    // Line 1 x=2..5 = 20, threshold 10
    threshold = 5'd10;
    fr = '0;
    for (int i = 2; i <= 5; i++) fr[1][i] = 5'd20;
    frame(fr, 8);
    check_box0("run4", 2, 5, 1, 1, 4, 1'b0);
    check_box1("run4", 2, 5, 1, 1, 4, 1'b0);
    tick(2);

    // Isolated hits at (3,0) and (6,2)
    fr = '0;
    fr[0][3] = 5'd20;
    fr[2][6] = 5'd20;
    frame(fr, 8);
    check_box0("iso", 0, 0, 0, 0, 0, 1'b1);
    check_box1("iso", 3, 6, 0, 2, 2, 1'b0);
    tick(2);

    // Hit at end of line 0 and start of line 1: the run must not span the gap
    fr = '0;
    fr[0][7] = 5'd20;
    fr[1][0] = 5'd20;
    frame(fr, 8);
    check_box0("span", 0, 0, 0, 0, 0, 1'b1);
    check_box1("span", 0, 7, 0, 1, 2, 1'b0);
    tick(2);

    // threshold 0: every pixel is a hit
    threshold = 5'd0;
    fr = '0;
    frame(fr, 8);
    check_box0("thr0", 0, 7, 0, 3, 32, 1'b0);
    check("thr0.count1", 32'(cnt1), 32'd32);
    tick(2);

    // Reset in the middle of line 2 discards the partial frame
    threshold  = 5'd10;
    pulse_mark = pulses;
    fr = '0;
    fr[0] = {8{5'd31}};
    fr[1] = {8{5'd31}};
    pixels(fr[0], 8); gap(2);
    pixels(fr[1], 8); gap(2);
    pixels(fr[1], 3);
    vtcvde = 1'b0; reset = 1'b1;
    tick(1);
    check("mid.empty", 32'(emp0), 32'd1);
    check("mid.count", 32'(cnt0), 32'd0);
    check("mid.xmax", 32'(x_max0), 32'd0);
    check("mid.valid", 32'(vld0), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(3);
    fr = '0;
    fr[2][4] = 5'd31;
    fr[2][5] = 5'd31;
    frame(fr, 8);
    check_box0("post", 4, 5, 2, 2, 2, 1'b0);
    check("post.pulses", pulses - pulse_mark, 32'd0);
    tick(1);
    check("post.pulses_after", pulses - pulse_mark, 32'd1);

    // Back-to-back frames; first has an over-long line 0 of 10 pixels at 31
    fr = '0;
    fr[0] = {8{5'd31}};
    frame(fr, 10);
    check_box0("long", 0, 7, 0, 0, 8, 1'b0);
    fr = '0;
    fr[3][1] = 5'd10;
    fr[3][2] = 5'd10;
    frame(fr, 8);
    check_box0("b2b", 1, 2, 3, 3, 2, 1'b0);
    check_box1("b2b", 1, 2, 3, 3, 2, 1'b0);
    tick(1);
    check("b2b.valid_low", 32'(vld0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
